// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel word assembler
// Words close on a full DATA_W bits or on a gap in the valid strobe.
module deserializer #(
  parameter int DATA_W   = 16,
  parameter int MOD_W    = 4,
  parameter int MIN_BITS = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam logic [MOD_W-1:0] LAST_IDX = MOD_W'(DATA_W - 1);
  localparam logic [MOD_W-1:0] MIN_CNT  = MOD_W'(MIN_BITS);
  localparam logic [MOD_W-1:0] ONE      = MOD_W'(1);

  logic [MOD_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sreg;
  logic [DATA_W-1:0] r_data;
  logic [MOD_W-1:0]  r_mod;
  logic              r_val;
  logic              r_err;

  logic [MOD_W-1:0]  w_shift;
  logic [DATA_W-1:0] w_sreg_cap;
  logic [MOD_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_sreg_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [MOD_W-1:0]  w_mod_nxt;
  logic              w_val_nxt;
  logic              w_err_nxt;

  // sreg is cleared at every word boundary, so OR-ing the new bit in is enough.
  assign w_shift    = LAST_IDX - r_cnt;
  assign w_sreg_cap = r_sreg | ({{(DATA_W-1){1'b0}}, ser_data_i} << w_shift);

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_sreg_nxt = r_sreg;
    w_data_nxt = r_data;
    w_mod_nxt  = r_mod;
    w_val_nxt  = 1'b0;
    w_err_nxt  = 1'b0;
    if (ser_data_val_i) begin
      if (r_cnt == LAST_IDX) begin
        w_data_nxt = w_sreg_cap;
        w_mod_nxt  = '0;
        w_val_nxt  = 1'b1;
        w_cnt_nxt  = '0;
        w_sreg_nxt = '0;
      end else begin
        w_sreg_nxt = w_sreg_cap;
        w_cnt_nxt  = r_cnt + ONE;
      end
    end else if (r_cnt != '0) begin
      // A gap closes a short word; too-short words are dropped and flagged.
      if (r_cnt >= MIN_CNT) begin
        w_data_nxt = r_sreg;
        w_mod_nxt  = r_cnt;
        w_val_nxt  = 1'b1;
      end else begin
        w_err_nxt  = 1'b1;
      end
      w_cnt_nxt  = '0;
      w_sreg_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt  <= '0;
      r_sreg <= '0;
      r_data <= '0;
      r_mod  <= '0;
      r_val  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sreg <= w_sreg_nxt;
      r_data <= w_data_nxt;
      r_mod  <= w_mod_nxt;
      r_val  <= w_val_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;
  assign err_o            = r_err;
  assign busy_o           = (r_cnt != '0);

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - randomized self-checking bench for deserializer
// Reference model keeps the current word as a queue of bits.
module tb_deserializer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ser_data_i;
  logic        ser_data_val_i;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        err_o;
  logic        busy_o;

  deserializer #(.DATA_W(16), .MOD_W(4), .MIN_BITS(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ser_data_i(ser_data_i),
    .ser_data_val_i(ser_data_val_i), .deser_data_o(deser_data_o),
    .deser_data_mod_o(deser_data_mod_o), .deser_data_val_o(deser_data_val_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  bit          q[$];
  logic [15:0] exp_data;
  logic [3:0]  exp_mod;
  logic        exp_val, exp_err, exp_busy;

  task automatic model_reset();
    q.delete();
    exp_data = '0; exp_mod = '0; exp_val = 0; exp_err = 0; exp_busy = 0;
  endtask

  task automatic model_deliver();
    exp_data = '0;
    foreach (q[i]) if (q[i]) exp_data = exp_data | (16'h8000 >> i);
    exp_mod = 4'(q.size() % 16);
    exp_val = 1;
    q.delete();
  endtask

  // Apply one cycle of input (called #1 after a rising edge), advance model.
  task automatic drive_cycle(input logic v, input logic b);
    ser_data_val_i = v;
    ser_data_i     = b;
    @(posedge clk_i);
    cycle++;
    exp_val = 0; exp_err = 0;
    if (v) begin
      q.push_back(b);
      if (q.size() == 16) model_deliver();
    end else if (q.size() > 0) begin
      if (q.size() >= 3) model_deliver();
      else begin exp_err = 1; q.delete(); end
    end
    exp_busy = (q.size() != 0);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 0; ser_data_i = 0; ser_data_val_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !== 23'h0) begin
      miscompares++;
      $display("FAIL reset: val=%b err=%b busy=%b mod=%0d data=%h, want all zero",
               deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o);
    end
    rst_n_i = 1;
  endtask

  task automatic test_full_word();
    logic [15:0] w = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      drive_cycle(1, w[i]);
      vectors++;
      if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !==
          {exp_val, exp_err, exp_busy, exp_mod, exp_data}) begin
        miscompares++;
        $display("FAIL full_word bit %0d: got val=%b err=%b busy=%b mod=%0d data=%h, want val=%b err=%b busy=%b mod=%0d data=%h",
                 15 - i, deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o,
                 exp_val, exp_err, exp_busy, exp_mod, exp_data);
      end
    end
    vectors++;
    if (!(deser_data_val_o === 1'b1 && deser_data_o === 16'hA5C3 && deser_data_mod_o === 4'd0)) begin
      miscompares++;
      $display("FAIL full_word_result: got val=%b data=%h mod=%0d, want 1 a5c3 0",
               deser_data_val_o, deser_data_o, deser_data_mod_o);
    end
    drive_cycle(0, 0);
    vectors++;
    if (deser_data_val_o !== 1'b0 || deser_data_o !== 16'hA5C3 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_word_hold: got val=%b data=%h busy=%b, want 0 a5c3 0",
               deser_data_val_o, deser_data_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w = 32'h1234_FFFF;
    int pulse_cyc[$];
    logic [15:0] pulse_dat[$];
    for (int i = 31; i >= 0; i--) begin
      drive_cycle(1, w[i]);
      if (deser_data_val_o === 1'b1) begin
        pulse_cyc.push_back(cycle);
        pulse_dat.push_back(deser_data_o);
      end
      vectors++;
      if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !==
          {exp_val, exp_err, exp_busy, exp_mod, exp_data}) begin
        miscompares++;
        $display("FAIL b2b bit %0d: got val=%b err=%b busy=%b mod=%0d data=%h, want val=%b err=%b busy=%b mod=%0d data=%h",
                 31 - i, deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o,
                 exp_val, exp_err, exp_busy, exp_mod, exp_data);
      end
    end
    vectors++;
    if (pulse_cyc.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d pulses, want 2", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != 16 || pulse_dat[0] !== 16'h1234 ||
                 pulse_dat[1] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL b2b_pulses: got spacing=%0d data=%h,%h, want 16 1234,ffff",
               pulse_cyc[1] - pulse_cyc[0], pulse_dat[0], pulse_dat[1]);
    end
    drive_cycle(0, 0);
  endtask

  task automatic test_short_word();
    logic [4:0] w = 5'b10110;
    for (int i = 4; i >= 0; i--) drive_cycle(1, w[i]);
    vectors++;
    if (busy_o !== 1'b1 || deser_data_val_o !== 1'b0) begin
      miscompares++;
      $display("FAIL short_busy: got busy=%b val=%b, want 1 0", busy_o, deser_data_val_o);
    end
    drive_cycle(0, 0);
    vectors++;
    if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !==
        {1'b1, 1'b0, 1'b0, 4'd5, 16'hB000} ||
        {exp_val, exp_mod, exp_data} !== {deser_data_val_o, deser_data_mod_o, deser_data_o}) begin
      miscompares++;
      $display("FAIL short_word: got val=%b err=%b busy=%b mod=%0d data=%h, want val=1 err=0 busy=0 mod=5 data=b000",
               deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o);
    end
    drive_cycle(0, 0);
  endtask

  task automatic test_err_word();
    drive_cycle(1, 1);
    drive_cycle(1, 1);
    drive_cycle(0, 0);
    vectors++;
    if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !==
        {1'b0, 1'b1, 1'b0, 4'd5, 16'hB000} || exp_err !== err_o) begin
      miscompares++;
      $display("FAIL err_word: got val=%b err=%b busy=%b mod=%0d data=%h, want val=0 err=1 busy=0 mod=5 data=b000",
               deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o);
    end
    drive_cycle(0, 0);
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse_width: got err=%b, want 0", err_o);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1, 1);
    drive_cycle(0, 0);
    vectors++;
    if ({deser_data_val_o, err_o, deser_data_mod_o, deser_data_o} !==
        {1'b1, 1'b0, 4'd3, 16'hE000}) begin
      miscompares++;
      $display("FAIL min_word: got val=%b err=%b mod=%0d data=%h, want val=1 err=0 mod=3 data=e000",
               deser_data_val_o, err_o, deser_data_mod_o, deser_data_o);
    end
    drive_cycle(0, 0);
  endtask

  task automatic test_async_reset();
    logic [15:0] w = 16'h0F0F;
    for (int i = 0; i < 9; i++) drive_cycle(1, 1'($urandom_range(0, 1)));
    #3 rst_n_i = 0;
    model_reset();
    #1;
    vectors++;
    if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !== 23'h0) begin
      miscompares++;
      $display("FAIL async_reset: val=%b err=%b busy=%b mod=%0d data=%h, want all zero",
               deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o);
    end
    ser_data_val_i = 0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1;
    for (int i = 15; i >= 0; i--) begin
      drive_cycle(1, w[i]);
      vectors++;
      if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !==
          {exp_val, exp_err, exp_busy, exp_mod, exp_data}) begin
        miscompares++;
        $display("FAIL post_reset bit %0d: got val=%b err=%b busy=%b mod=%0d data=%h, want val=%b err=%b busy=%b mod=%0d data=%h",
                 15 - i, deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o,
                 exp_val, exp_err, exp_busy, exp_mod, exp_data);
      end
    end
    vectors++;
    if (!(deser_data_val_o === 1'b1 && deser_data_o === 16'h0F0F && deser_data_mod_o === 4'd0)) begin
      miscompares++;
      $display("FAIL post_reset_word: got val=%b data=%h mod=%0d, want 1 0f0f 0",
               deser_data_val_o, deser_data_o, deser_data_mod_o);
    end
    drive_cycle(0, 0);
  endtask

  task automatic test_interleaved_idle();
    logic [15:0] w = 16'h8001;
    for (int i = 15; i >= 8; i--) drive_cycle(1, w[i]);
    drive_cycle(0, 0);
    vectors++;
    if ({deser_data_val_o, deser_data_mod_o, deser_data_o} !== {1'b1, 4'd8, 16'h8000}) begin
      miscompares++;
      $display("FAIL idle_first: got val=%b mod=%0d data=%h, want 1 8 8000",
               deser_data_val_o, deser_data_mod_o, deser_data_o);
    end
    for (int i = 7; i >= 0; i--) drive_cycle(1, w[i]);
    drive_cycle(0, 0);
    vectors++;
    if ({deser_data_val_o, deser_data_mod_o, deser_data_o} !== {1'b1, 4'd8, 16'h0100}) begin
      miscompares++;
      $display("FAIL idle_second: got val=%b mod=%0d data=%h, want 1 8 0100",
               deser_data_val_o, deser_data_mod_o, deser_data_o);
    end
    drive_cycle(0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive_cycle(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
      vectors++;
      if ({deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o} !==
          {exp_val, exp_err, exp_busy, exp_mod, exp_data}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got val=%b err=%b busy=%b mod=%0d data=%h, want val=%b err=%b busy=%b mod=%0d data=%h",
                 n, deser_data_val_o, err_o, busy_o, deser_data_mod_o, deser_data_o,
                 exp_val, exp_err, exp_busy, exp_mod, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_short_word();
    test_err_word();
    test_async_reset();
    test_interleaved_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's serializer.
- Collects an MSB-first serial bit stream, qualified by a valid strobe, into a parallel word of up to DATA_W bits.
- Emits the word with a one-cycle valid pulse and a valid-bit count.
- Sits at the ingress of a serial link, feeding parallel data to downstream logic.

Parameters:
- DATA_W, 16, width of the parallel output word.
- MOD_W, 4, width of the bit-count output; equals $clog2(DATA_W).
- MIN_BITS, 3, minimum bits for a legal short word; shorter words are discarded and flagged.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- ser_data_i  input  1  serial data bit, MSB of the word first.
- ser_data_val_i  input  1  ser_data_i valid this cycle.
- deser_data_o  output  DATA_W  assembled word, left-aligned, unused LSBs zero.
- deser_data_mod_o  output  MOD_W  number of valid bits in deser_data_o; 0 means DATA_W.
- deser_data_val_o  output  1  one-cycle pulse: deser_data_o and deser_data_mod_o valid.
- err_o  output  1  one-cycle pulse: short word (<MIN_BITS bits) discarded.
- busy_o  output  1  word assembly in progress.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - bit counter cnt=0 and shift register=0.
  - deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, err_o=0.
  - busy_o=0 (it is combinational from cnt).
  - Deassertion is synchronous to clk_i by system convention; the first edge after deassertion may capture a bit.
- Internal state: cnt (0..DATA_W-1), shift register sreg[DATA_W-1:0]. No further FSM; the word phase is implied by cnt.
- Bit capture: on an edge with ser_data_val_i=1, write ser_data_i to sreg[DATA_W-1-cnt]. This forms MSB first with left alignment.
- Full word: the edge capturing bit index DATA_W-1 closes the word.
  - Registered outputs load: deser_data_o = the completed word, deser_data_mod_o=0, deser_data_val_o=1.
  - Latency: outputs visible in the cycle after the sampling edge.
  - On the same edge, cnt=0 and sreg cleared.
- Back-to-back words: if ser_data_val_i stays 1, the next edge captures bit 0 of the new word. There is no idle cycle between words.
- Short word: an edge with ser_data_val_i=0 and cnt>0 closes the word.
  - If cnt>=MIN_BITS: deser_data_o=sreg (bits below index DATA_W-cnt are zero), deser_data_mod_o=cnt, deser_data_val_o=1.
  - If cnt<MIN_BITS: deser_data_val_o=0, err_o=1, data dropped; deser_data_o and deser_data_mod_o hold their previous values.
  - In both cases, cnt=0 and sreg cleared on that edge.
- Idle: ser_data_val_i=0 with cnt=0 changes nothing. deser_data_val_o and err_o return to 0.
- Output hold: deser_data_o and deser_data_mod_o hold the last delivered word until the next delivery. deser_data_val_o and err_o are single-cycle pulses, never high simultaneously.
- busy_o: combinational, equals (cnt != 0). Low in the cycle the closing bit or gap is sampled after that edge.
- No backpressure: the downstream block must accept every pulse.
- Reset mid-word: partial data is lost, with no val or err pulse. The first valid bit after reset is bit 0 of a new word.
- Counter arithmetic:
  - cnt is MOD_W bits and increments by 1 per accepted bit.
  - The wrap from DATA_W-1 to 0 occurs only through the full-word rule, never by overflow.
  - deser_data_mod_o equals cnt truncated to MOD_W bits, so a full word reads 0.

Test Plan:
1. Reset then 16 consecutive valid bits of 0xA5C3 MSB first -> one cycle after 16th bit: deser_data_o=0xA5C3, mod=0, val pulse 1 cycle; busy_o high during bits 2..16.
2. Two words 0x1234 then 0xFFFF with no gap (32 valid cycles) -> val pulses exactly 16 cycles apart, data 0x1234 then 0xFFFF.
3. 5 bits 1,0,1,1,0 then val low -> next cycle after gap edge: deser_data_o=0xB000, mod=5, val=1; err_o stays 0.
4. 2 bits 1,1 then val low -> err_o pulses 1 cycle, val stays 0, deser_data_o unchanged from previous word; then 3 bits 1,1,1 + gap -> 0xE000, mod=3.
5. Assert rst_n_i low asynchronously (mid-cycle) after 9 bits -> all outputs 0 immediately, no pulses. Then a full 0x0F0F -> delivered correctly with mod=0.
6. Interleaved idle: 16 bits of 0x8001 with val low for 1 cycle between bits 8 and 9 -> short word 0x8000 mod=8 delivered, then 8-bit word 0x0100 mod=8.
